fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  fetch address (word aligned)
- imem_rsp_valid_i  in  1  response data valid
- imem_rsp_data_i  in  32  fetched instruction word
- redirect_i  in  1  branch/jump redirect from execute
- redirect_pc_i  in  32  redirect target
- dec_valid_o  out  1  instruction valid to decode
- dec_ready_i  in  1  decode accepts instruction
- dec_instr_o  out  32  instruction word
- dec_pc_o  out  32  PC of dec_instr_o
- dec_illegal_o  out  1  opcode not in the supported set

Function
REQ-004 The block SHALL hold a 32-bit PC register, with bits [1:0] always 0.
REQ-005 The FSM SHALL have three states: REQ (request pending), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-006 In REQ, imem_req_valid_o SHALL be (!dec_valid_o || dec_ready_i) && !redirect_i.
REQ-007 imem_req_addr_o SHALL equal PC, held stable while imem_req_valid_o && !imem_req_ready_i.
REQ-008 On an accepted request (valid && ready), the FSM SHALL move REQ->WAIT.
REQ-009 At most one request SHALL be outstanding.
REQ-010 imem_req_valid_o SHALL be 0 in WAIT and DROP.
REQ-011 Responses SHALL arrive no earlier than the cycle after acceptance; imem_rsp_valid_i outside WAIT/DROP SHALL be ignored.
REQ-012 On imem_rsp_valid_i in WAIT without redirect, next edge:
- dec_instr_o <= data, dec_pc_o <= PC, dec_valid_o <= 1
- PC <= PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
- FSM -> REQ
REQ-013 Output registers SHALL be held unchanged while dec_valid_o && !dec_ready_i.
REQ-014 dec_valid_o SHALL clear on dec_valid_o && dec_ready_i unless REQ-012 reloads it in the same cycle.
REQ-015 dec_illegal_o SHALL be registered with dec_instr_o and SHALL be 1 iff instr[6:0] is not one of 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1101111.
REQ-016 Redirect SHALL have the highest priority; next edge:
- PC <= {redirect_pc_i[31:2], 2'b00}
- dec_valid_o <= 0
REQ-017 Redirect FSM transitions SHALL be:
- REQ -> REQ
- WAIT without same-cycle response -> DROP
- WAIT with same-cycle response -> REQ, response discarded
- DROP -> DROP
REQ-018 In DROP, imem_rsp_valid_i SHALL be discarded with no change to outputs or PC, and the FSM SHALL move to REQ.
REQ-019 A redirect in the same cycle as the DROP response SHALL update PC, and the FSM SHALL go to REQ.
REQ-020 Back-to-back redirects SHALL each overwrite PC; the last one wins.
REQ-021 Sustained throughput SHALL be one instruction per two cycles with zero-latency memory ready and 1-cycle response.

Reset
REQ-022 While rst_n=0, the block SHALL force, asynchronously:
- PC=RESET_PC, FSM=REQ
- dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, dec_illegal_o=0
REQ-023 A reset asserted mid-operation SHALL abandon any outstanding request; responses arriving after reset release while in REQ SHALL be ignored.
REQ-024 After reset release, the first request SHALL be issued in the first cycle, with imem_req_addr_o=RESET_PC.

Verification
REQ-025 Sequential fetch scenario: RESET_PC=0x100, memory ready=1, 1-cycle response -> dec_pc_o sequence 0x100, 0x104, 0x108; dec_illegal_o=0 for 0x00000013.
REQ-026 Decode stall scenario: dec_ready_i=0 for 5 cycles with dec_valid_o=1 -> dec_instr_o/dec_pc_o stable, no new request until dec_ready_i=1.
REQ-027 Redirect-in-WAIT scenario: redirect_i with redirect_pc_i=0x203 while WAIT; response 3 cycles later -> response dropped, next request address 0x200, dec_valid_o stays 0 until the 0x200 response.
REQ-028 Redirect-with-response scenario: redirect_i coincident with imem_rsp_valid_i -> no instruction delivered; next request address = target.
REQ-029 Illegal-and-wrap scenario: PC=0xFFFF_FFFC, data 0x0000007F -> dec_illegal_o=1, dec_pc_o=0xFFFF_FFFC, next request address 0x0.
REQ-030 Reset-mid-WAIT scenario: rst_n low while WAIT, response arrives after release -> response ignored, request issued at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word fetch at a time, hands the returned
// word to decode with its PC, and squashes in-flight fetches on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,

    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    output logic        dec_illegal_o
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_target;
    logic        req_fire;
    logic        rsp_take;
    logic        dec_fire;
    logic        unused_redirect_low;

    // Opcodes outside this set are flagged so decode can raise an exception.
    function automatic logic opcode_illegal(input logic [6:0] opcode);
        logic illegal;
        illegal = 1'b1;
        case (opcode)
            7'b0000011,
            7'b0010011,
            7'b0010111,
            7'b0100011,
            7'b0110011,
            7'b0110111,
            7'b1100011,
            7'b1101111: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    // A new fetch may only start once the decode slot is free or being freed.
    assign imem_req_valid_o = (state == ST_REQ) && (!dec_valid_o || dec_ready_i) && !redirect_i;
    assign imem_req_addr_o  = pc;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign rsp_take = (state == ST_WAIT) && imem_rsp_valid_i && !redirect_i;
    assign dec_fire = dec_valid_o && dec_ready_i;

    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                if (req_fire) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_next = ST_REQ;
                end else if (redirect_i) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid_i) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    always_comb begin
        pc_next = pc;
        if (redirect_i) begin
            pc_next = redirect_target;
        end else if (rsp_take) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
            pc    <= RESET_PC_ALIGNED;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect kills whatever sits in the decode slot, even a stalled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_o   <= 1'b0;
            dec_instr_o   <= 32'd0;
            dec_pc_o      <= 32'd0;
            dec_illegal_o <= 1'b0;
        end else if (redirect_i) begin
            dec_valid_o <= 1'b0;
        end else if (rsp_take) begin
            dec_valid_o   <= 1'b1;
            dec_instr_o   <= imem_rsp_data_i;
            dec_pc_o      <= pc;
            dec_illegal_o <= opcode_illegal(imem_rsp_data_i[6:0]);
        end else if (dec_fire) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_illegal;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: one optional in-flight fetch (possibly squashed) and one optional
    // word waiting in the decode slot.
    bit          m_out;
    bit          m_squashed;
    bit          m_have;
    logic [31:0] m_pc;
    logic [31:0] m_item_pc;
    logic [31:0] m_item_instr;
    logic        m_item_ill;

    bit          mem_pending = 1'b0;
    int          mem_due = 0;
    int          mem_lat = 1;
    bit          force_en = 1'b0;
    logic [31:0] force_data = 32'd0;
    bit          stale_inject = 1'b0;

    logic [6:0] legal_ops [8] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h6F};

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_instr_o      (dec_instr),
        .dec_pc_o         (dec_pc),
        .dec_illegal_o    (dec_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic ref_illegal(input logic [31:0] instr);
        foreach (legal_ops[i]) begin
            if (instr[6:0] == legal_ops[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] pick_data();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = legal_ops[$urandom_range(0, 7)];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_out       = 1'b0;
        m_squashed  = 1'b0;
        m_have      = 1'b0;
        m_pc        = RST_PC;
        mem_pending = 1'b0;
    endtask

    task automatic checkOutput(input logic exp_req);
        check("dec_valid", 32'(dec_valid), 32'(m_have));
        if (m_have) begin
            check("dec_pc", dec_pc, m_item_pc);
            check("dec_instr", dec_instr, m_item_instr);
            check("dec_illegal", 32'(dec_illegal), 32'(m_item_ill));
        end
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        check("req_addr", imem_req_addr, m_pc);
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance
    // the model by what the next rising edge must do.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic drdy, input logic mrdy);
        logic exp_req;
        logic hit;
        @(negedge clk);
        rst_n          = 1'b1;
        redirect       = redir;
        redirect_pc    = rpc;
        dec_ready      = drdy;
        imem_req_ready = mrdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pending && cyc >= mem_due) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = force_en ? force_data : pick_data();
            mem_pending    = 1'b0;
        end else if (stale_inject) begin
            imem_rsp_valid = 1'b1;
            stale_inject   = 1'b0;
        end else if (!mem_pending && !force_en && $urandom_range(0, 7) == 0) begin
            imem_rsp_valid = 1'b1;
        end
        #1;
        exp_req = !m_out && (!m_have || drdy) && !redir;
        checkOutput(exp_req);
        hit = m_out && imem_rsp_valid;
        if (redir) begin
            m_pc   = {rpc[31:2], 2'b00};
            m_have = 1'b0;
            if (hit) begin
                m_out      = 1'b0;
                m_squashed = 1'b0;
            end else if (m_out) begin
                m_squashed = 1'b1;
            end
        end else begin
            if (m_have && drdy) m_have = 1'b0;
            if (hit) begin
                m_out = 1'b0;
                if (!m_squashed) begin
                    m_have       = 1'b1;
                    m_item_pc    = m_pc;
                    m_item_instr = imem_rsp_data;
                    m_item_ill   = ref_illegal(imem_rsp_data);
                    m_pc         = m_pc + 32'd4;
                end
                m_squashed = 1'b0;
            end
            if (exp_req && mrdy) begin
                m_out       = 1'b1;
                mem_pending = 1'b1;
                mem_due     = cyc + mem_lat;
            end
        end
        cyc++;
    endtask

    // Reset lands between clock edges; memory forgets any pending fetch.
    task automatic doReset(input int n);
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        modelReset();
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_illegal", 32'(dec_illegal), 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        modelReset();
        doReset(2);

        // Sequential fetch with single-cycle memory.
        mem_lat = 1; force_en = 1'b1; force_data = 32'h0000_0013;
        repeat (8) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Decode stall for five cycles.
        repeat (5) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect while a slow fetch is outstanding.
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        mem_lat = 4;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0203, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect coincident with the response, then back-to-back redirects.
        mem_lat = 1;
        repeat (2) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0604, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Illegal opcode at the top of the address space, PC wraps to zero.
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        force_data = 32'h0000_007F;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Reset while waiting; the stale response after release is ignored.
        force_data = 32'h0000_0013;
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        mem_lat = 3;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        doReset(2);
        mem_lat = 1;
        stale_inject = 1'b1;
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Random traffic with one reset in the middle.
        force_en = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) doReset(1);
            mem_lat = $urandom_range(1, 3);
            applyStimulus(($urandom_range(0, 9) == 0), $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
